// File: rtl/ysyx_24110015_ifu_bus.sv
// Instruction fetch unit: one AXI-lite style read per instruction, delivered to decode
// with a valid/ready handshake; the next PC arrives from the retiring stage via wb_pc.
module ysyx_24110015_ifu_bus #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic        out_fault,
    output logic        out_valid,
    input  logic        out_ready,
    input  logic        wb_valid,
    input  logic [31:0] wb_pc,
    output logic [31:0] fetch_cnt
);

    typedef enum logic [2:0] {
        S_BOOT,
        S_ADDR,
        S_DATA,
        S_DELIVER,
        S_WAIT_WB
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] opc_q, opc_d;
    logic        fault_q, fault_d;
    logic [31:0] cnt_q, cnt_d;

    // Handshake outputs decode straight from state, so reset drops them at once.
    assign arvalid   = (state_q == S_ADDR);
    assign rready    = (state_q == S_DATA);
    assign out_valid = (state_q == S_DELIVER);
    assign araddr    = pc_q;
    assign out_inst  = inst_q;
    assign out_pc    = opc_q;
    assign out_fault = fault_q;
    assign fetch_cnt = cnt_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        opc_d   = opc_q;
        fault_d = fault_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_BOOT: begin
                state_d = S_ADDR;
                pc_d    = RESET_PC;
            end
            S_ADDR: begin
                if (arready) state_d = S_DATA;
            end
            S_DATA: begin
                if (rvalid) begin
                    inst_d  = rdata;
                    fault_d = (rresp != 2'b00);
                    opc_d   = pc_q;
                    state_d = S_DELIVER;
                end
            end
            S_DELIVER: begin
                if (out_ready) begin
                    cnt_d   = cnt_q + 32'd1;
                    state_d = S_WAIT_WB;
                end
            end
            S_WAIT_WB: ;
            default: state_d = S_BOOT;
        endcase

        // Redirect: from WAIT_WB, or in the same cycle as the delivery handshake.
        if ((state_q == S_WAIT_WB || (state_q == S_DELIVER && out_ready)) && wb_valid) begin
            pc_d = wb_pc;
            if (wb_pc[1:0] != 2'b00) begin
                // Misaligned target faults locally without touching the bus.
                inst_d  = 32'h0;
                fault_d = 1'b1;
                opc_d   = wb_pc;
                state_d = S_DELIVER;
            end else begin
                state_d = S_ADDR;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_BOOT;
            pc_q    <= RESET_PC;
            inst_q  <= 32'h0;
            opc_q   <= 32'h0;
            fault_q <= 1'b0;
            cnt_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            opc_q   <= opc_d;
            fault_q <= fault_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_ysyx_24110015_ifu_bus.sv
// Directed bench for ysyx_24110015_ifu_bus: inputs change and outputs are sampled on the falling edge.
module tb_ysyx_24110015_ifu_bus;

    logic        clk;
    logic        rst;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_fault;
    logic        out_valid;
    logic        out_ready;
    logic        wb_valid;
    logic [31:0] wb_pc;
    logic [31:0] fetch_cnt;

    int errors = 0;
    int checks = 0;

    ysyx_24110015_ifu_bus #(.RESET_PC(32'h8000_0000)) dut (
        .clk       (clk),
        .rst       (rst),
        .araddr    (araddr),
        .arvalid   (arvalid),
        .arready   (arready),
        .rdata     (rdata),
        .rresp     (rresp),
        .rvalid    (rvalid),
        .rready    (rready),
        .out_inst  (out_inst),
        .out_pc    (out_pc),
        .out_fault (out_fault),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .wb_valid  (wb_valid),
        .wb_pc     (wb_pc),
        .fetch_cnt (fetch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b0; arready = 1'b0; rdata = 32'h0; rresp = 2'b00; rvalid = 1'b0;
        out_ready = 1'b0; wb_valid = 1'b0; wb_pc = 32'h0;
        tick(); tick();
        chk("rst_arvalid", 32'(arvalid), 32'd0);
        chk("rst_rready", 32'(rready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_inst", out_inst, 32'h0);
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_out_fault", 32'(out_fault), 32'd0);
        chk("rst_fetch_cnt", fetch_cnt, 32'h0);

        // Basic fetch
        rst = 1'b1; arready = 1'b1; out_ready = 1'b1;
        chk("boot_arvalid", 32'(arvalid), 32'd0);
        tick();
        chk("first_arvalid", 32'(arvalid), 32'd1);
        chk("first_araddr", araddr, 32'h8000_0000);
        chk("first_rready", 32'(rready), 32'd0);
        rvalid = 1'b1; rdata = 32'h0010_0093; rresp = 2'b00;
        tick();
        chk("data_rready", 32'(rready), 32'd1);
        chk("data_arvalid", 32'(arvalid), 32'd0);
        tick();
        chk("dlv_valid", 32'(out_valid), 32'd1);
        chk("dlv_inst", out_inst, 32'h0010_0093);
        chk("dlv_pc", out_pc, 32'h8000_0000);
        chk("dlv_fault", 32'(out_fault), 32'd0);
        chk("dlv_cnt_before", fetch_cnt, 32'd0);
        tick();
        chk("hs_cnt", fetch_cnt, 32'd1);
        chk("wait_out_valid", 32'(out_valid), 32'd0);
        chk("wait_arvalid", 32'(arvalid), 32'd0);
        chk("wait_rready", 32'(rready), 32'd0);
        tick();
        chk("wait_hold_arvalid", 32'(arvalid), 32'd0);
        chk("wait_hold_out_valid", 32'(out_valid), 32'd0);

        // Redirect from WAIT_WB, then address held under backpressure
        rvalid = 1'b0; arready = 1'b0; wb_valid = 1'b1; wb_pc = 32'h8000_0004;
        tick();
        wb_valid = 1'b0;
        chk("redir_arvalid", 32'(arvalid), 32'd1);
        chk("redir_araddr", araddr, 32'h8000_0004);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_arvalid", 32'(arvalid), 32'd1);
            chk("stall_araddr", araddr, 32'h8000_0004);
            chk("stall_rready", 32'(rready), 32'd0);
        end
        arready = 1'b1; rvalid = 1'b1; rdata = 32'h0000_0513; rresp = 2'b00; out_ready = 1'b0;
        tick();
        chk("stall_data_rready", 32'(rready), 32'd1);
        chk("stall_data_arvalid", 32'(arvalid), 32'd0);
        arready = 1'b0;
        tick();
        rvalid = 1'b0;
        chk("d2_valid", 32'(out_valid), 32'd1);
        chk("d2_inst", out_inst, 32'h0000_0513);
        chk("d2_pc", out_pc, 32'h8000_0004);

        // Decode backpressure; wb_valid before the handshake must be ignored
        wb_valid = 1'b1; wb_pc = 32'h8000_0020;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_inst", out_inst, 32'h0000_0513);
            chk("hold_pc", out_pc, 32'h8000_0004);
            chk("hold_fault", 32'(out_fault), 32'd0);
            chk("hold_cnt", fetch_cnt, 32'd1);
            chk("hold_arvalid", 32'(arvalid), 32'd0);
        end
        out_ready = 1'b1; wb_pc = 32'h8000_0010;
        tick();
        wb_valid = 1'b0;
        chk("direct_arvalid", 32'(arvalid), 32'd1);
        chk("direct_araddr", araddr, 32'h8000_0010);
        chk("direct_cnt", fetch_cnt, 32'd2);
        chk("direct_out_valid", 32'(out_valid), 32'd0);

        // Error response, then misaligned redirect
        arready = 1'b1; rvalid = 1'b1; rdata = 32'hDEAD_BEEF; rresp = 2'b10; out_ready = 1'b0;
        tick();
        chk("err_rready", 32'(rready), 32'd1);
        tick();
        chk("err_fault", 32'(out_fault), 32'd1);
        chk("err_inst", out_inst, 32'hDEAD_BEEF);
        chk("err_pc", out_pc, 32'h8000_0010);
        rvalid = 1'b0; arready = 1'b0; rresp = 2'b00; out_ready = 1'b1;
        wb_valid = 1'b1; wb_pc = 32'h8000_0006;
        tick();
        wb_valid = 1'b0; out_ready = 1'b0;
        chk("mis_arvalid", 32'(arvalid), 32'd0);
        chk("mis_valid", 32'(out_valid), 32'd1);
        chk("mis_fault", 32'(out_fault), 32'd1);
        chk("mis_inst", out_inst, 32'h0);
        chk("mis_pc", out_pc, 32'h8000_0006);
        chk("mis_cnt", fetch_cnt, 32'd3);
        tick();
        chk("mis_hold_arvalid", 32'(arvalid), 32'd0);
        chk("mis_hold_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("mis_hs_cnt", fetch_cnt, 32'd4);
        chk("mis_hs_valid", 32'(out_valid), 32'd0);

        // Reset asserted while in DATA
        wb_valid = 1'b1; wb_pc = 32'h8000_0040;
        tick();
        wb_valid = 1'b0; arready = 1'b1;
        chk("pre_rst_araddr", araddr, 32'h8000_0040);
        tick();
        chk("pre_rst_rready", 32'(rready), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("async_arvalid", 32'(arvalid), 32'd0);
        chk("async_rready", 32'(rready), 32'd0);
        chk("async_out_valid", 32'(out_valid), 32'd0);
        chk("async_out_inst", out_inst, 32'h0);
        chk("async_out_pc", out_pc, 32'h0);
        chk("async_cnt", fetch_cnt, 32'h0);
        tick();
        rst = 1'b1; arready = 1'b0; rvalid = 1'b1; rdata = 32'h1234_5678;
        tick();
        chk("post_rst_arvalid", 32'(arvalid), 32'd1);
        chk("post_rst_araddr", araddr, 32'h8000_0000);
        chk("post_rst_rready", 32'(rready), 32'd0);
        chk("post_rst_out_valid", 32'(out_valid), 32'd0);
        chk("post_rst_out_inst", out_inst, 32'h0);
        tick();
        chk("stale_arvalid", 32'(arvalid), 32'd1);
        chk("stale_out_valid", 32'(out_valid), 32'd0);

        // Counter wrap
        rvalid = 1'b0;
        force dut.cnt_q = 32'hFFFF_FFFF;
        tick();
        release dut.cnt_q;
        chk("preload_cnt", fetch_cnt, 32'hFFFF_FFFF);
        arready = 1'b1; rvalid = 1'b1; rdata = 32'h0000_0073; rresp = 2'b00; out_ready = 1'b1;
        tick();
        tick();
        chk("wrap_inst", out_inst, 32'h0000_0073);
        chk("wrap_valid", 32'(out_valid), 32'd1);
        chk("wrap_cnt_before", fetch_cnt, 32'hFFFF_FFFF);
        tick();
        chk("wrap_cnt", fetch_cnt, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
